// File: rtl/decode_issue_stage_if.sv
// Issue bus from decode_issue_stage to RS/LSB/ROB.
// master drives pulses and decoded fields; slave observes.
interface decode_issue_stage_if #(
  parameter int ROB_POS_W = 4
);
  logic                 issue;
  logic                 rs_en;
  logic                 lsb_en;
  logic                 is_ready;
  logic [ROB_POS_W-1:0] rob_pos;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 funct7;
  logic [4:0]           rd;
  logic [31:0]          imm;
  logic [31:0]          pc;
  logic                 pred_jump;
  logic [31:0]          rs1_val;
  logic [31:0]          rs2_val;
  logic [ROB_POS_W:0]   rs1_rob_id;
  logic [ROB_POS_W:0]   rs2_rob_id;

  modport master (
    output issue, rs_en, lsb_en, is_ready,
    output rob_pos, opcode, funct3, funct7,
    output rd, imm, pc, pred_jump,
    output rs1_val, rs2_val,
    output rs1_rob_id, rs2_rob_id
  );

  modport slave (
    input issue, rs_en, lsb_en, is_ready,
    input rob_pos, opcode, funct3, funct7,
    input rd, imm, pc, pred_jump,
    input rs1_val, rs2_val,
    input rs1_rob_id, rs2_rob_id
  );
endinterface

// File: rtl/decode_issue_stage.sv
// Instruction queue + decode + operand resolve + issue.
// Ports: fetch push, regfile/ROB/CDB lookup, backpressure, iss bus.
module decode_issue_stage #(
  parameter int IQ_DEPTH  = 4,
  parameter int CDB_NUM   = 2,
  parameter int ROB_POS_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         rollback,
  input  logic                         inst_valid,
  input  logic [31:0]                  inst,
  input  logic [31:0]                  inst_pc,
  input  logic                         inst_pred_jump,
  output logic                         iq_full,
  output logic [4:0]                   reg_rs1,
  output logic [4:0]                   reg_rs2,
  input  logic [31:0]                  reg_rs1_val,
  input  logic [31:0]                  reg_rs2_val,
  input  logic [ROB_POS_W:0]           reg_rs1_rob_id,
  input  logic [ROB_POS_W:0]           reg_rs2_rob_id,
  output logic [ROB_POS_W-1:0]         rob_rs1_pos,
  output logic [ROB_POS_W-1:0]         rob_rs2_pos,
  input  logic                         rob_rs1_ready,
  input  logic [31:0]                  rob_rs1_val,
  input  logic                         rob_rs2_ready,
  input  logic [31:0]                  rob_rs2_val,
  input  logic                         rs_full,
  input  logic                         lsb_full,
  input  logic                         rob_full,
  input  logic [ROB_POS_W-1:0]         nxt_rob_pos,
  input  logic [CDB_NUM-1:0]           cdb_valid,
  input  logic [CDB_NUM*ROB_POS_W-1:0] cdb_rob_pos,
  input  logic [CDB_NUM*32-1:0]        cdb_val,
  decode_issue_stage_if.master         iss
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RES_W = ROB_POS_W + 33;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [31:0]      q_inst [IQ_DEPTH];
  logic [31:0]      q_pc   [IQ_DEPTH];
  logic             q_pj   [IQ_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic        push;
  logic        pop;
  logic        head_valid;
  logic [31:0] h;
  logic [6:0]  op;
  logic        d_rs;
  logic        d_lsb;
  logic        d_rdy;
  logic        use1;
  logic        use2;
  logic [4:0]  d_rd;
  logic [31:0] d_imm;

  logic [ROB_POS_W:0] r1_id;
  logic [ROB_POS_W:0] r2_id;
  logic [31:0]        r1_val;
  logic [31:0]        r2_val;
  logic [RES_W-1:0]   res1;
  logic [RES_W-1:0]   res2;

  // Returns {rob_id, value}; rob_id 0 means value is final.
  function automatic logic [RES_W-1:0] resolve(
    input logic [ROB_POS_W:0]           id,
    input logic [31:0]                  rval,
    input logic                         rob_rdy,
    input logic [31:0]                  rob_v,
    input logic [CDB_NUM-1:0]           cv,
    input logic [CDB_NUM*ROB_POS_W-1:0] cp,
    input logic [CDB_NUM*32-1:0]        cd
  );
    logic [RES_W-1:0] r;
    r = {id, 32'h0};
    if (!id[ROB_POS_W]) begin
      r = {{(ROB_POS_W+1){1'b0}}, rval};
    end else if (rob_rdy) begin
      r = {{(ROB_POS_W+1){1'b0}}, rob_v};
    end else begin
      // descending scan: lowest matching channel wins
      for (int i = CDB_NUM - 1; i >= 0; i--) begin
        if (cv[i] &&
            cp[i*ROB_POS_W +: ROB_POS_W] == id[ROB_POS_W-1:0]) begin
          r = {{(ROB_POS_W+1){1'b0}}, cd[i*32 +: 32]};
        end
      end
    end
    return r;
  endfunction

  assign iq_full    = (count == CNT_W'(IQ_DEPTH));
  assign head_valid = (count != '0);
  assign h          = q_inst[head];
  assign op         = h[6:0];

  assign reg_rs1     = h[19:15];
  assign reg_rs2     = h[24:20];
  assign rob_rs1_pos = reg_rs1_rob_id[ROB_POS_W-1:0];
  assign rob_rs2_pos = reg_rs2_rob_id[ROB_POS_W-1:0];

  always_comb begin
    d_rs  = 1'b0;
    d_lsb = 1'b0;
    d_rdy = 1'b0;
    use1  = 1'b1;
    use2  = 1'b1;
    d_rd  = h[11:7];
    d_imm = 32'h0;
    unique case (1'b1)
      op == OP_STORE: begin
        d_lsb = 1'b1;
        d_rdy = 1'b1;
        d_rd  = 5'd0;
        d_imm = {{20{h[31]}}, h[31:25], h[11:7]};
      end
      op == OP_LOAD: begin
        d_lsb = 1'b1;
        use2  = 1'b0;
        d_imm = {{20{h[31]}}, h[31:20]};
      end
      op == OP_OPIMM || op == OP_JALR: begin
        d_rs  = 1'b1;
        use2  = 1'b0;
        d_imm = {{20{h[31]}}, h[31:20]};
      end
      op == OP_OP: begin
        d_rs = 1'b1;
      end
      op == OP_BRANCH: begin
        d_rs  = 1'b1;
        d_rd  = 5'd0;
        d_imm = {{19{h[31]}}, h[31], h[7],
                 h[30:25], h[11:8], 1'b0};
      end
      op == OP_JAL: begin
        d_rs  = 1'b1;
        use1  = 1'b0;
        use2  = 1'b0;
        d_imm = {{11{h[31]}}, h[31], h[19:12],
                 h[20], h[30:21], 1'b0};
      end
      op == OP_LUI || op == OP_AUIPC: begin
        d_rs  = 1'b1;
        use1  = 1'b0;
        use2  = 1'b0;
        d_imm = {h[31:12], 12'h0};
      end
      default: begin
        d_rdy = 1'b1;
      end
    endcase
  end

  always_comb begin
    res1 = resolve(reg_rs1_rob_id, reg_rs1_val,
                   rob_rs1_ready, rob_rs1_val,
                   cdb_valid, cdb_rob_pos, cdb_val);
    res2 = resolve(reg_rs2_rob_id, reg_rs2_val,
                   rob_rs2_ready, rob_rs2_val,
                   cdb_valid, cdb_rob_pos, cdb_val);
    r1_id  = use1 ? res1[RES_W-1:32] : '0;
    r1_val = use1 ? res1[31:0]       : 32'h0;
    r2_id  = use2 ? res2[RES_W-1:32] : '0;
    r2_val = use2 ? res2[31:0]       : 32'h0;
  end

  assign push = inst_valid && !iq_full && rdy && !rollback;
  assign pop  = head_valid && rdy && !rollback && !rob_full &&
                !(d_rs && rs_full) && !(d_lsb && lsb_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        q_inst[i] <= 32'h0;
        q_pc[i]   <= 32'h0;
        q_pj[i]   <= 1'b0;
      end
    end else if (rollback) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (push) begin
        q_inst[tail] <= inst;
        q_pc[tail]   <= inst_pc;
        q_pj[tail]   <= inst_pred_jump;
        tail         <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss.issue      <= 1'b0;
      iss.rs_en      <= 1'b0;
      iss.lsb_en     <= 1'b0;
      iss.is_ready   <= 1'b0;
      iss.rob_pos    <= '0;
      iss.opcode     <= 7'h0;
      iss.funct3     <= 3'h0;
      iss.funct7     <= 1'b0;
      iss.rd         <= 5'h0;
      iss.imm        <= 32'h0;
      iss.pc         <= 32'h0;
      iss.pred_jump  <= 1'b0;
      iss.rs1_val    <= 32'h0;
      iss.rs2_val    <= 32'h0;
      iss.rs1_rob_id <= '0;
      iss.rs2_rob_id <= '0;
    end else if (rollback) begin
      iss.issue    <= 1'b0;
      iss.rs_en    <= 1'b0;
      iss.lsb_en   <= 1'b0;
      iss.is_ready <= 1'b0;
    end else if (rdy) begin
      iss.issue    <= pop;
      iss.rs_en    <= pop && d_rs;
      iss.lsb_en   <= pop && d_lsb;
      iss.is_ready <= pop && d_rdy;
      if (pop) begin
        iss.rob_pos    <= nxt_rob_pos;
        iss.opcode     <= op;
        iss.funct3     <= h[14:12];
        iss.funct7     <= h[30];
        iss.rd         <= d_rd;
        iss.imm        <= d_imm;
        iss.pc         <= q_pc[head];
        iss.pred_jump  <= q_pj[head];
        iss.rs1_val    <= r1_val;
        iss.rs2_val    <= r2_val;
        iss.rs1_rob_id <= r1_id;
        iss.rs2_rob_id <= r2_id;
      end
    end
  end

endmodule
